// File: rtl/aibnd_dcc_cal_ctrl_if.sv
// Control/status bundle between the DCC calibration controller and its environment.
// The master side owns the register-bus controls and the phase-detector input.
interface aibnd_dcc_cal_ctrl_if #(
    parameter int unsigned CODE_W = 5
);
    logic              rb_dcc_byp;
    logic [CODE_W-1:0] rb_dcc_code_ovr;
    logic              rb_track_en;
    logic              cal_start;
    logic              pd_out;
    logic [CODE_W-1:0] dcc_code;
    logic              dcc_lock;
    logic              dcc_busy;

    modport master (
        output rb_dcc_byp,
        output rb_dcc_code_ovr,
        output rb_track_en,
        output cal_start,
        output pd_out,
        input  dcc_code,
        input  dcc_lock,
        input  dcc_busy
    );

    modport slave (
        input  rb_dcc_byp,
        input  rb_dcc_code_ovr,
        input  rb_track_en,
        input  cal_start,
        input  pd_out,
        output dcc_code,
        output dcc_lock,
        output dcc_busy
    );
endinterface

// File: rtl/aibnd_dcc_cal_ctrl.sv
// DCC delay-code calibration: SAR binary search on a majority-voted phase-detector
// decision, optional +/-1 tracking after lock, and a register-bus bypass override.
module aibnd_dcc_cal_ctrl #(
    parameter int unsigned CODE_W     = 5,
    parameter int unsigned SETTLE_CYC = 16,
    parameter int unsigned NUM_SAMP   = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    aibnd_dcc_cal_ctrl_if.slave  bus
);

    localparam int unsigned IdxW   = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam int unsigned CntMax = (SETTLE_CYC > NUM_SAMP) ? SETTLE_CYC : NUM_SAMP;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned OnesW  = $clog2(NUM_SAMP + 1);

    localparam logic [CODE_W-1:0] CodeMid    = {1'b1, {(CODE_W-1){1'b0}}};
    localparam logic [IdxW-1:0]   IdxTop     = IdxW'(CODE_W - 1);
    localparam logic [CntW-1:0]   SettleLast = CntW'(SETTLE_CYC - 1);
    localparam logic [CntW-1:0]   SampLast   = CntW'(NUM_SAMP - 1);
    localparam logic [OnesW-1:0]  VoteHalf   = OnesW'(NUM_SAMP / 2);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StSettle = 3'd1;
    localparam logic [2:0] StSample = 3'd2;
    localparam logic [2:0] StUpdate = 3'd3;
    localparam logic [2:0] StDone   = 3'd4;
    localparam logic [2:0] StTrack  = 3'd5;

    logic [2:0]        state_q, state_d;
    logic              pd_meta_q, pd_sync_q;
    logic              cal_start_q;
    logic [CODE_W-1:0] code_q, code_d;
    logic              lock_q, lock_d;
    logic              track_mode_q, track_mode_d;
    logic [IdxW-1:0]   bit_idx_q, bit_idx_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [OnesW-1:0]  ones_q, ones_d;
    logic              start_edge;
    logic              decision;

    assign start_edge = bus.cal_start & ~cal_start_q;
    assign decision   = (ones_q > VoteHalf);

    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        lock_d       = lock_q;
        track_mode_d = track_mode_q;
        bit_idx_d    = bit_idx_q;
        cnt_d        = cnt_q;
        ones_d       = ones_q;

        if (bus.rb_dcc_byp) begin
            // Override code is registered here so it persists after bypass is released.
            state_d      = StIdle;
            code_d       = bus.rb_dcc_code_ovr;
            lock_d       = 1'b0;
            track_mode_d = 1'b0;
            cnt_d        = '0;
            ones_d       = '0;
        end else if (start_edge) begin
            state_d      = StSettle;
            code_d       = CodeMid;
            bit_idx_d    = IdxTop;
            lock_d       = 1'b0;
            track_mode_d = 1'b0;
            cnt_d        = '0;
            ones_d       = '0;
        end else begin
            unique case (state_q)
                StSettle: begin
                    if (cnt_q == SettleLast) begin
                        cnt_d   = '0;
                        ones_d  = '0;
                        state_d = StSample;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StSample: begin
                    ones_d = ones_q + OnesW'(pd_sync_q);
                    if (cnt_q == SampLast) begin
                        cnt_d   = '0;
                        state_d = StUpdate;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StUpdate: begin
                    if (track_mode_q) begin
                        if (!bus.rb_track_en) begin
                            state_d = StDone;
                        end else begin
                            // Saturating step: the end codes never wrap.
                            if (decision) begin
                                if (code_q != '0) code_d = code_q - 1'b1;
                            end else begin
                                if (code_q != '1) code_d = code_q + 1'b1;
                            end
                            state_d = StSettle;
                        end
                    end else begin
                        if (decision) code_d[bit_idx_q] = 1'b0;
                        if (bit_idx_q != '0) begin
                            code_d[bit_idx_q - 1'b1] = 1'b1;
                            bit_idx_d                = bit_idx_q - 1'b1;
                            state_d                  = StSettle;
                        end else begin
                            lock_d  = 1'b1;
                            state_d = bus.rb_track_en ? StTrack : StDone;
                        end
                    end
                end
                StTrack: begin
                    track_mode_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = StSettle;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            pd_meta_q    <= 1'b0;
            pd_sync_q    <= 1'b0;
            cal_start_q  <= 1'b0;
            code_q       <= CodeMid;
            lock_q       <= 1'b0;
            track_mode_q <= 1'b0;
            bit_idx_q    <= '0;
            cnt_q        <= '0;
            ones_q       <= '0;
        end else begin
            state_q      <= state_d;
            pd_meta_q    <= bus.pd_out;
            pd_sync_q    <= pd_meta_q;
            cal_start_q  <= bus.cal_start;
            code_q       <= code_d;
            lock_q       <= lock_d;
            track_mode_q <= track_mode_d;
            bit_idx_q    <= bit_idx_d;
            cnt_q        <= cnt_d;
            ones_q       <= ones_d;
        end
    end

    assign bus.dcc_code = code_q;
    assign bus.dcc_lock = lock_q;
    assign bus.dcc_busy = (state_q == StSettle) || (state_q == StSample) ||
                          (state_q == StUpdate) || (state_q == StTrack);

endmodule

// File: doc/aibnd_dcc_cal_ctrl.md
Name: aibnd_dcc_cal_ctrl

Overview:
Calibration controller for the DCC delay path, sitting directly downstream of the DCC delay replica.
- Consumes the phase-detector decision taken on the replica clocks (clkrep0/clkrep1).
- Runs a SAR binary search on the DCC delay code, then optional ±1 tracking.
- Drives the code word and lock/bypass status to the DCC delay line and its replica.

Parameters:
CODE_W, 5, width of DCC delay code
SETTLE_CYC, 16, clk cycles waited after every code change before sampling (≥2)
NUM_SAMP, 7, pd samples per decision; odd, ≥1; majority vote

Ports:
clk  input  1  calibration clock
reset  input  1  asynchronous active-high reset
rb_dcc_byp  input  1  bypass: hold override code, no calibration
rb_dcc_code_ovr  input  CODE_W  code driven while bypassed
rb_track_en  input  1  enable ±1 tracking after lock
cal_start  input  1  level; rising edge (internally detected) starts calibration
pd_out  input  1  async phase-detector result; 1 = duty high (reduce code)
dcc_code  output  CODE_W  delay code to DCC delay line / replica
dcc_lock  output  1  SAR search complete
dcc_busy  output  1  calibration in progress (SAR or tracking)

Behaviour:
Reset values (async, immediate on reset=1):
- dcc_code = 1<<(CODE_W-1) (mid, 5'b10000); dcc_lock=0; dcc_busy=0.
- State IDLE; sync flops, counters, vote count and bit index cleared; cal_start edge register = 0.

pd_out handling:
- pd_out passes through a 2-flop synchronizer; only pd_sync is used.

States:
- IDLE: dcc_busy=0. On cal_start rising edge with rb_dcc_byp=0:
  - dcc_code <= mid; bit_idx <= CODE_W-1; dcc_lock <= 0; go SETTLE.
- SETTLE: busy=1. Count SETTLE_CYC cycles, then go SAMPLE. Counter cleared on entry.
- SAMPLE: NUM_SAMP consecutive cycles; ones-count accumulates pd_sync. Decision = (ones > NUM_SAMP/2). Then go UPDATE.
- UPDATE (1 cycle), SAR mode:
  - If decision=1, clear dcc_code[bit_idx].
  - If bit_idx>0: set dcc_code[bit_idx-1]; bit_idx--; go SETTLE.
  - If bit_idx==0: dcc_lock<=1; go TRACK if rb_track_en, else DONE.
- UPDATE (1 cycle), tracking mode:
  - decision=1 → code-1, saturating at 0.
  - decision=0 → code+1, saturating at all-ones.
  - Saturated step leaves the code unchanged. Go SETTLE.
- DONE: busy=0, lock=1, code held. A cal_start rising edge restarts the search (lock drops on the IDLE-equivalent transition).
- TRACK: routes to SETTLE with tracking flag set; busy=1, lock=1.
  - rb_track_en deasserting is sampled only in UPDATE; tracking then exits to DONE.

Bypass:
- rb_dcc_byp=1 in any state: next cycle go IDLE.
- dcc_code follows rb_dcc_code_ovr combinationally from a registered copy (1-cycle latency).
- lock=0, busy=0.
- Deassertion returns to IDLE holding the last override code; a new cal_start edge is required to calibrate.

Boundary cases:
- cal_start edge during SETTLE/SAMPLE/UPDATE/TRACK: restarts SAR from mid next cycle; counters cleared.
- Reset mid-search: all state returns to reset values immediately.
- Latency: one SAR bit = SETTLE_CYC+NUM_SAMP+1 cycles. Full lock = CODE_W×(SETTLE_CYC+NUM_SAMP+1) cycles after the edge-detect cycle; 5×24 = 120 cycles with defaults.
- dcc_code changes only in UPDATE, in the start cycle, or under bypass/reset; it is glitch-free registered.

Test Plan:
- pd_out held 0 (duty low), defaults, cal_start pulse → code 10000,11000,11100,11110,11111; dcc_lock=1 at cycle 120±2 after edge; busy falls; final code 5'h1F.
- pd_out=1 iff code ≥ 5'd13 (model), track off → search ends dcc_code=5'd12, lock=1, DONE stable ≥200 cycles.
- Same model, rb_track_en=1 → after lock code dithers 12↔13 each 24 cycles; busy=1, lock stays 1; pd_out forced 1 drives code down to 0 and holds (no wrap).
- pd_out toggling with 3 of 7 samples high per window → decision 0 every step; glitch-vote majority verified, result 5'h1F.
- rb_dcc_byp=1 mid-search with rb_dcc_code_ovr=5'd7 → next cycle IDLE, lock=0, busy=0, dcc_code=7 one cycle later; release + cal_start → restarts from 10000.
- Async reset asserted at cycle 50 of search (between clk edges) → outputs immediately 10000/0/0; cal_start re-edge after release → full 120-cycle search repeats correctly.
